// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronises and optionally debounces in_port, latches edges per bit
// into a W1C capture register and raises a masked level interrupt. Reads are registered (1 cycle).
module pio_in_edge_irq #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rdmux;
  logic [31:0]      r_readdata;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign w_stable = w_sync;
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0]    r_cnt [WIDTH];
      logic [WIDTH-1:0] r_stable;

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stable <= '0;
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] != r_stable[i]) begin
              if (r_cnt[i] == CNT_LAST) begin
                r_stable[i] <= w_sync[i];
                r_cnt[i]    <= '0;
              end else begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
              end
            end else begin
              r_cnt[i] <= '0;
            end
          end
        end
      end

      assign w_stable = r_stable;
    end
  endgenerate

  assign w_rise = w_stable & ~r_prev;
  assign w_fall = ~w_stable & r_prev;

  always_comb begin
    w_edge = w_rise | w_fall;
    if (EDGE_TYPE == 0)      w_edge = w_rise;
    else if (EDGE_TYPE == 1) w_edge = w_fall;
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a same-cycle edge survives the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_prev    <= w_stable;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (address)
      2'd0:    w_rdmux[WIDTH-1:0] = w_stable;
      2'd2:    w_rdmux[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rdmux[WIDTH-1:0] = r_edgecap;
      default: w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdmux;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);
  assign w_unused = ^writedata;

endmodule
